// File: rtl/out_serial_tx_if.sv
// out_serial_tx_if: OUT-port bus from the CPU to the serial transmitter.
// The CPU side drives a one-cycle strobe (doOut) together with the byte
// on the data bus (outData). The transmitter only ever listens.
interface out_serial_tx_if;
    logic       doOut;
    logic [7:0] outData;

    modport master (
        output doOut,
        output outData
    );

    modport slave (
        input doOut,
        input outData
    );
endinterface

// File: rtl/out_serial_tx.sv
// out_serial_tx: captures bytes written by CPU OUT instructions into a small
// circular FIFO and shifts them out one at a time as 8N1-style async frames
// (start bit low, 8 data bits LSB first, stop bit high). The line idles high.
// Bytes arriving while the FIFO is full are dropped; a sticky flag and a
// saturating counter record the loss.
//
// Optional build macro: OUT_SERIAL_PARITY_EN
//   defined   -> an even-parity bit is inserted between bit 7 and the stop bit
//   undefined -> plain 10-bit frames, no parity state
module out_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    out_serial_tx_if.slave           bus,
    output logic                     txd,
    output logic                     busy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               dropCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef OUT_SERIAL_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [LW-1:0] r_level;

    // Loss tracking
    logic          r_overflow;
    logic [7:0]    r_dropCount;

    // Transmitter state
    state_t        r_state;
    logic          r_txd;
    logic [CW-1:0] r_cyc;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
`ifdef OUT_SERIAL_PARITY_EN
    logic          r_par;
`endif

    // Handshake decisions, all derived from registered state plus the strobe
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_cycLast;

    assign w_full    = (r_level == LVL_FULL);
    assign w_pop     = (r_state == S_IDLE) && (r_level != '0);
    assign w_push    = bus.doOut && (!w_full || w_pop);
    assign w_drop    = bus.doOut && w_full && !w_pop;
    assign w_cycLast = (r_cyc == CYC_LAST);

    assign txd       = r_txd;
    assign busy      = (r_state != S_IDLE) || (r_level != '0);
    assign full      = w_full;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign dropCount = r_dropCount;

    // Store an accepted byte at the write pointer; storage itself needs no reset
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wrPtr] <= bus.outData;
        end
    end

    // Advance the circular pointers and keep occupancy; push+pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Record strobes that found the FIFO full; the counter stops at 255
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_dropCount <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropCount != 8'hFF) begin
                r_dropCount <= r_dropCount + 8'd1;
            end
        end
    end

    // Frame sequencer: one state per frame field, each field held CLKS_PER_BIT cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
            r_cyc   <= '0;
            r_bit   <= 3'd0;
            r_sh    <= 8'd0;
`ifdef OUT_SERIAL_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    r_cyc <= '0;
                    r_bit <= 3'd0;
                    if (w_pop) begin
                        r_sh    <= r_mem[r_rdPtr];
`ifdef OUT_SERIAL_PARITY_EN
                        r_par   <= ^r_mem[r_rdPtr];
`endif
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_cycLast) begin
                        r_cyc   <= '0;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                        r_txd   <= r_sh[0];
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end

                S_DATA: begin
                    if (w_cycLast) begin
                        r_cyc <= '0;
                        if (r_bit == 3'd7) begin
`ifdef OUT_SERIAL_PARITY_EN
                            r_state <= S_PARITY;
                            r_txd   <= r_par;
`else
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_sh  <= r_sh >> 1;
                            r_txd <= r_sh[1];
                        end
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end

`ifdef OUT_SERIAL_PARITY_EN
                S_PARITY: begin
                    if (w_cycLast) begin
                        r_cyc   <= '0;
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end
`endif

                S_STOP: begin
                    r_txd <= 1'b1;
                    if (w_cycLast) begin
                        r_cyc   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_cyc   <= '0;
                    r_bit   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_serial_tx.sv
// tb_out_serial_tx: drives OUT strobes into out_serial_tx, decodes the serial
// line with an independent frame receiver and compares received bytes against
// a queue of bytes the bench expects to see, in strobe order. A second
// instance with a very slow bit rate stays mid-frame long enough to saturate
// the drop counter.
module tb_out_serial_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef OUT_SERIAL_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    typedef struct {
        bit         doOut;
        logic [7:0] data;
        bit         accept;
        logic [2:0] expLevel;
        bit         expFull;
        bit         expOverflow;
        logic [7:0] expDrop;
        bit         expBusy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;

    logic       txd, busy, full, overflow;
    logic [2:0] level;
    logic [7:0] dropCount;

    logic       txd2, busy2, full2, overflow2;
    logic [2:0] level2;
    logic [7:0] dropCount2;

    int         compareCount = 0;
    int         errorCount   = 0;
    int         cycleCount   = 0;
    int         frameCount   = 0;

    logic [7:0] expq[$];
    int         startLog[$];

    vec_t       vecs[7];

    out_serial_tx_if if1 ();
    out_serial_tx_if if2 ();

    out_serial_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (if1),
        .txd       (txd),
        .busy      (busy),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .dropCount (dropCount)
    );

    out_serial_tx #(.CLKS_PER_BIT(400), .DEPTH(DEPTH)) dutSlow (
        .clk       (clk),
        .reset     (reset),
        .bus       (if2),
        .txd       (txd2),
        .busy      (busy2),
        .full      (full2),
        .level     (level2),
        .overflow  (overflow2),
        .dropCount (dropCount2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit doo, input logic [7:0] d, input bit accept);
        if1.doOut   = doo;
        if1.outData = d;
        if (doo && accept) expq.push_back(d);
        @(posedge clk);
        #1;
        if1.doOut = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while ((expq.size() != 0 || busy !== 1'b0) && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= maxCycles) checkOutput("drainTimeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    // Independent line receiver: samples every cycle on the falling edge
    initial begin
        logic [11:0] bits;
        logic [7:0]  rxByte;
        bit          aborted;
        bit          shapeOk;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || txd !== 1'b0) continue;
            startLog.push_back(cycleCount);
            bits    = '0;
            aborted = 1'b0;
            shapeOk = 1'b1;
            for (int n = 0; n < FRAME_CYC; n++) begin
                int b;
                if (n != 0) @(negedge clk);
                if (reset !== 1'b0) begin
                    aborted = 1'b1;
                    break;
                end
                b = n / CPB;
                if (n % CPB == 0) bits[b] = txd;
                else if (txd !== bits[b]) shapeOk = 1'b0;
            end
            if (!aborted) begin
                rxByte = bits[8:1];
                frameCount++;
                checkOutput("frameShape", {30'd0, shapeOk, bits[NBITS-1]}, 32'd3);
`ifdef OUT_SERIAL_PARITY_EN
                checkOutput("parityBit", {31'd0, bits[9]}, {31'd0, ^rxByte});
`endif
                if (expq.size() == 0) checkOutput("unexpectedFrame", {24'd0, rxByte}, 32'hFFFF_FFFF);
                else checkOutput("rxByte", {24'd0, rxByte}, {24'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        bit stay;
        int frameBefore;

        vecs[0] = '{1'b1, 8'h01, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[1] = '{1'b1, 8'h02, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[2] = '{1'b1, 8'h03, 1'b1, 3'd2, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[3] = '{1'b1, 8'h04, 1'b1, 3'd3, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[4] = '{1'b1, 8'h05, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[5] = '{1'b1, 8'h06, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1, 1'b1};

        reset       = 1'b1;
        if1.doOut   = 1'b0;
        if1.outData = 8'h00;
        if2.doOut   = 1'b0;
        if2.outData = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstTxd", txd, 1);
        checkOutput("rstLevel", level, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFull", full, 0);
        checkOutput("rstOverflow", overflow, 0);
        checkOutput("rstDrop", dropCount, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single byte: latency, line shape and busy duration
        applyStimulus(1'b1, 8'hA5, 1'b1);
        checkOutput("latLevel", level, 1);
        checkOutput("latTxd", txd, 1);
        @(posedge clk);
        #1;
        checkOutput("popTxd", txd, 0);
        checkOutput("popLevel", level, 0);
        repeat (FRAME_CYC - 1) @(posedge clk);
        #1;
        checkOutput("busyLastCycle", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("busyDropped", busy, 0);
        checkOutput("levelAfterFrame", level, 0);
        waitDrain(200);

        // Back-to-back frames with one idle cycle between them
        startLog.delete();
        applyStimulus(1'b1, 8'h41, 1'b1);
        applyStimulus(1'b1, 8'h42, 1'b1);
        waitDrain(300);
        checkOutput("gapCycles", (startLog.size() >= 2) ? startLog[1] - startLog[0] : 0, FRAME_CYC + 1);
        checkOutput("overflowAfterPair", overflow, 0);

        // Parity-relevant bytes (odd and even popcount)
        applyStimulus(1'b1, 8'h07, 1'b1);
        applyStimulus(1'b1, 8'h03, 1'b1);
        waitDrain(300);

        // Fill past capacity from an idle, empty FIFO
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].doOut, vecs[i].data, vecs[i].accept);
            checkOutput($sformatf("vecLevel%0d", i), level, vecs[i].expLevel);
            checkOutput($sformatf("vecFull%0d", i), full, vecs[i].expFull);
            checkOutput($sformatf("vecOvf%0d", i), overflow, vecs[i].expOverflow);
            checkOutput($sformatf("vecDrop%0d", i), dropCount, vecs[i].expDrop);
            checkOutput($sformatf("vecBusy%0d", i), busy, vecs[i].expBusy);
        end
        waitDrain(600);
        checkOutput("overflowSticky", overflow, 1);

        // Slow instance stays mid-frame: 5 fill strobes then 300 dropped ones
        for (int i = 1; i <= 305; i++) begin
            if2.doOut   = 1'b1;
            if2.outData = i[7:0];
            @(posedge clk);
            #1;
            if (i == 6 || i == 259 || i == 260 || i == 305)
                checkOutput($sformatf("satDrop%0d", i), dropCount2, (i - 5 > 255) ? 255 : i - 5);
        end
        if2.doOut = 1'b0;
        checkOutput("satOverflow", overflow2, 1);
        checkOutput("satFull", full2, 1);
        checkOutput("satLevel", level2, 4);

        // Reset in the middle of data bit 3 with two bytes still queued
        applyStimulus(1'b1, 8'h10, 1'b1);
        applyStimulus(1'b1, 8'h11, 1'b1);
        applyStimulus(1'b1, 8'h12, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        checkOutput("preResetLevel", level, 2);
        reset = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        checkOutput("midRstTxd", txd, 1);
        checkOutput("midRstLevel", level, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstOverflow", overflow, 0);
        checkOutput("midRstDrop", dropCount, 0);
        checkOutput("midRstSlowDrop", dropCount2, 0);
        reset = 1'b0;
        frameBefore = frameCount;
        stay = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1) stay = 1'b0;
        end
        checkOutput("stayHigh", stay, 1);
        checkOutput("noFramesAfterReset", frameCount - frameBefore, 0);
        checkOutput("busyAfterReset", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule

// File: doc/out_serial_tx.md
Name: out_serial_tx

Overview:
- Downstream consumer of the CPU output port: captures each byte written by an OUT instruction into a small FIFO.
- Shifts each captured byte out on a single serial line as an 8N1-style async frame, so program output can leave the simulation or board.
- Decouples CPU speed from line rate and counts bytes lost to overflow.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit (>=1).
- DEPTH, 4, FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- doOut  in  1  OUT strobe from the CPU, one cycle per written byte.
- outData  in  8  byte on dbus, valid when doOut=1.
- txd  out  1  serial line; idles high.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- full  out  1  FIFO holds DEPTH entries.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a strobe arrived while full.
- dropCount  out  8  count of dropped bytes; saturates at 255.

Behaviour:
- Reset (any cycle, including mid-frame): at the next edge txd=1, FSM=IDLE, FIFO empty (level=0), overflow=0, dropCount=0, bit and cycle counters=0. Any frame in progress is abandoned; no partial bits follow.
- All outputs are registered except busy and full, which are combinational from registered state.
- FIFO:
  - Circular buffer with read and write pointers.
  - Push when doOut=1 and (not full, or a pop occurs in the same cycle).
  - Pop and push in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- Overflow: doOut=1 while full with no pop that cycle -> the byte is discarded; overflow<=1; dropCount increments unless it is already 255.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if level>0 -> pop the head into shift register sh, go to START, txd<=0, cyc<=0.
  - START: hold txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit=0 and txd<=sh[0].
  - DATA: each bit lasts CLKS_PER_BIT cycles; bits go LSB first. After bit 7 -> STOP, txd<=1.
  - STOP: hold txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Cycle counter cyc counts 0..CLKS_PER_BIT-1. State and bit advance when cyc==CLKS_PER_BIT-1.
- Back-to-back frames: in the cycle STOP completes, the FSM goes to IDLE. The next pop happens one cycle later, so frames are separated by one extra idle-high cycle.
- Latency: strobe sampled at edge N with FSM idle and FIFO empty -> level=1 after edge N; pop and txd=0 after edge N+1.
- Frame length: 10*CLKS_PER_BIT cycles, plus 1 IDLE cycle between frames.
- A byte is never reordered or duplicated. Bytes leave in strobe order.

Optional Feature:
- Macro: OUT_SERIAL_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent after bit 7 and before the stop bit, in state PARITY, for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: there is no PARITY state, and frames are 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset, then outData=0xA5 with one doOut strobe (CLKS_PER_BIT=4) -> txd sequence, 4 cycles per bit: 0, then 1,0,1,0,0,1,0,1, then 1. busy drops 41 cycles after the strobe; level back to 0.
- Strobes 0x41 and 0x42 on consecutive cycles -> two frames in order with exactly 1 idle-high cycle between them. overflow=0.
- 6 strobes on consecutive cycles, 0x01..0x06, DEPTH=4 -> 0x01 popped at edge 2; 0x02..0x05 stored; 0x06 dropped. full=1, overflow=1, dropCount=1. Line output is 0x01..0x05 in order.
- 300 strobes while full and the FSM is held mid-frame -> dropCount saturates at 255; overflow stays 1.
- Assert reset during bit 3 of a frame with 2 bytes queued -> txd=1 at the next edge and stays high. level=0, busy=0, overflow=0, and nothing further is transmitted.
- With OUT_SERIAL_PARITY_EN, send 0x07 -> parity bit=1 after bit 7; frame is 44 cycles. Send 0x03 -> parity bit=0.
